c_mult_pipe: RTL and testbench
==============================

// Module: c_mult_pipe
// PURPOSE
//  Pipelined, parametrised fixed-point complex multiplier for the FFT butterfly/twiddle path.
//  Computes (a_re + j*a_im) * (b_re + j*b_im) in signed two's complement.
//  Three register stages with a valid/ready handshake; a sideband tag travels with each sample.
//  Replaces the combinational 32-bit complex multiply where timing closure and back-pressure are needed.
// PARAMETERS
//  DATA_W  16  width of each real/imag operand and result (signed)
//  FRAC_W  15  fractional bits of the Q format (default Q1.15); must satisfy 1 <= FRAC_W < DATA_W
//  TAG_W   8   width of the sideband tag (e.g. FFT bin index), passed through unchanged
// PORTS
//  clk      in   1          rising-edge clock
//  rst      in   1          synchronous, active-high reset
//  i_valid  in   1          input sample valid
//  i_ready  out  1          block can accept an input this cycle
//  a_re     in   DATA_W     operand A real part
//  a_im     in   DATA_W     operand A imaginary part
//  b_re     in   DATA_W     operand B (twiddle) real part
//  b_im     in   DATA_W     operand B (twiddle) imaginary part
//  i_tag    in   TAG_W      sideband tag
//  conj_i   in   1          conjugate B before multiplying (present only with CMULT_CONJ_EN)
//  o_valid  out  1          result valid
//  o_ready  in   1          downstream accepts the result
//  o_re     out  DATA_W     result real part
//  o_im     out  DATA_W     result imaginary part
//  o_tag    out  TAG_W      tag aligned with the result
//  o_ovf    out  1          re or im saturated for this result (qualified by o_valid)
// BEHAVIOUR
//  - Pipeline enable: en = ~o_valid | o_ready; i_ready = en (combinational). No combinational path from i_* to o_*.
//  - Input transfer when i_valid & i_ready. Output transfer when o_valid & o_ready.
//  - Stage handling:
//    - The pipeline shifts only when en=1; when en=0 every stage register, including o_*, holds.
//    - Bubbles (valid=0) shift like data; they are not collapsed.
//  - S1: register operands, tag and valid. With conj, b_im is negated at this stage.
//  - S2: four full products, each 2*DATA_W bits signed: rr=a_re*b_re, ii=a_im*b_im, ri=a_re*b_im, ir=a_im*b_re.
//  - S3 (output registers):
//    - re_w = rr - ii and im_w = ri + ir, each 2*DATA_W+1 bits (sign-extended, no wrap).
//    - Round half-up: add 1<<(FRAC_W-1), then arithmetic shift right by FRAC_W.
//    - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//    - o_ovf = 1 if either component clipped.
//  - Latency is exactly 3 clk from input transfer to o_valid when o_ready is held high. Throughput is 1 sample/clk.
//  - Reset: all valid bits cleared, so o_valid=0; o_re=o_im=0, o_tag=0, o_ovf=0. i_ready=1 in the cycle after reset.
//  - Reset mid-operation discards all in-flight samples. No output is produced for them.
//  - Simultaneous o_ready fall and i_valid rise: the input is accepted only if o_valid=0 in that cycle.
//  - Corner case: (-2^(DATA_W-1))*(-2^(DATA_W-1)) must saturate to the max positive value with o_ovf=1. It must never wrap.
// CONFIGURATION
//  CMULT_CONJ_EN defined:
//    - Port conj_i exists and is sampled with the input transfer.
//    - conj_i=1 computes A*conj(B), for IFFT twiddles.
//    - Negating b_im = -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
//  CMULT_CONJ_EN undefined: conj_i port absent; B is always used as given; the negation logic is not built.
// TESTING  (DATA_W=16, FRAC_W=15)
//  1. A=(0x4000,0x4000), B=(0x4000,0xC000), o_ready=1 -> o_re=0x4000, o_im=0x0000, o_ovf=0, o_valid 3 clk after transfer.
//  2. A=(0x8000,0), B=(0x8000,0) -> o_re=0x7FFF, o_im=0x0000, o_ovf=1.
//  3. Rounding: A=(0x0001,0), B=(0x4000,0) gives 0.5 LSB -> o_re=0x0001. A=(0xFFFF,0), B=(0x4000,0) -> o_re=0x0000.
//  4. Stream 8 tagged samples (tag 0..7) with o_ready low for 4 clk mid-stream:
//     -> o_* stable while stalled, i_ready low while o_valid high, all 8 results in order, no loss or duplication.
//  5. Assert rst with 2 samples in flight -> the next cycle o_valid=0 and outputs are zero; no stale result emerges afterwards.
//  6. CMULT_CONJ_EN: A=(0x4000,0x4000), B=(0x4000,0x4000), conj_i=1 -> o_re=0x4000, o_im=0x0000. With conj_i=0 -> (0x0000,0x4000).

Source files
------------

// File: rtl/c_mult_pipe.sv
// Three-stage signed fixed-point complex multiplier with round half-up, saturation and tag sideband.
// Optional CMULT_CONJ_EN adds conj_i to compute A*conj(B). Requires 1 <= FRAC_W < DATA_W.
module c_mult_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic        [TAG_W-1:0]  i_tag,
`ifdef CMULT_CONJ_EN
  input  logic                     conj_i,
`endif
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic signed [DATA_W-1:0] o_re,
  output logic signed [DATA_W-1:0] o_im,
  output logic        [TAG_W-1:0]  o_tag,
  output logic                     o_ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 2;
  localparam logic signed [SW-1:0] RND  = SW'(1) << (FRAC_W - 1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Handshake: a transfer happens on any edge where valid & ready are both high.
  // The whole pipe advances together on en, so a stalled output freezes every stage.
  logic en;
  assign en      = ~o_valid | o_ready;
  assign i_ready = en;

  logic signed [DATA_W-1:0] b_im_eff;
`ifdef CMULT_CONJ_EN
  always_comb begin
    b_im_eff = b_im;
    if (conj_i) begin
      if (b_im == {1'b1, {(DATA_W-1){1'b0}}}) b_im_eff = {1'b0, {(DATA_W-1){1'b1}}};
      else                                     b_im_eff = -b_im;
    end
  end
`else
  assign b_im_eff = b_im;
`endif

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
  logic        [TAG_W-1:0]  s1_tag;
  logic                     s2_valid;
  logic signed [PW-1:0]     s2_rr, s2_ii, s2_ri, s2_ir;
  logic        [TAG_W-1:0]  s2_tag;

  logic signed [SW-1:0]     re_w, im_w, re_sh, im_sh;
  logic                     re_hi, re_lo, im_hi, im_lo;
  logic signed [DATA_W-1:0] re_sat, im_sat;

  // Extra guard bits keep the rounding add from wrapping before the shift.
  always_comb begin
    re_w   = {{2{s2_rr[PW-1]}}, s2_rr} - {{2{s2_ii[PW-1]}}, s2_ii};
    im_w   = {{2{s2_ri[PW-1]}}, s2_ri} + {{2{s2_ir[PW-1]}}, s2_ir};
    re_sh  = (re_w + RND) >>> FRAC_W;
    im_sh  = (im_w + RND) >>> FRAC_W;
    re_hi  = re_sh > MAXV;
    re_lo  = re_sh < MINV;
    im_hi  = im_sh > MAXV;
    im_lo  = im_sh < MINV;
    re_sat = re_hi ? MAXV[DATA_W-1:0] : (re_lo ? MINV[DATA_W-1:0] : re_sh[DATA_W-1:0]);
    im_sat = im_hi ? MAXV[DATA_W-1:0] : (im_lo ? MINV[DATA_W-1:0] : im_sh[DATA_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
      s2_tag   <= '0;
      o_valid  <= 1'b0;
      o_re     <= '0;
      o_im     <= '0;
      o_tag    <= '0;
      o_ovf    <= 1'b0;
    end else if (en) begin
      s1_valid <= i_valid;
      s1_a_re  <= a_re;
      s1_a_im  <= a_im;
      s1_b_re  <= b_re;
      s1_b_im  <= b_im_eff;
      s1_tag   <= i_tag;
      s2_valid <= s1_valid;
      s2_rr    <= PW'(s1_a_re) * PW'(s1_b_re);
      s2_ii    <= PW'(s1_a_im) * PW'(s1_b_im);
      s2_ri    <= PW'(s1_a_re) * PW'(s1_b_im);
      s2_ir    <= PW'(s1_a_im) * PW'(s1_b_re);
      s2_tag   <= s1_tag;
      o_valid  <= s2_valid;
      o_re     <= re_sat;
      o_im     <= im_sat;
      o_tag    <= s2_tag;
      o_ovf    <= re_hi | re_lo | im_hi | im_lo;
    end
  end

endmodule

// File: tb/tb_c_mult_pipe.sv
// Directed self-checking bench for c_mult_pipe (DATA_W=16, FRAC_W=15, TAG_W=8).
// Define CMULT_CONJ_EN for both files to exercise the conjugate option.
module tb_c_mult_pipe;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 15;
  localparam int TAG_W  = 8;
  localparam int W      = TAG_W + 2 * DATA_W;

  logic                     clk;
  logic                     rst;
  logic                     i_valid;
  logic                     i_ready;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic        [TAG_W-1:0]  i_tag;
`ifdef CMULT_CONJ_EN
  logic                     conj_i;
`endif
  logic                     o_valid;
  logic                     o_ready;
  logic signed [DATA_W-1:0] o_re, o_im;
  logic        [TAG_W-1:0]  o_tag;
  logic                     o_ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  c_mult_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .i_tag(i_tag),
`ifdef CMULT_CONJ_EN
    .conj_i(conj_i),
`endif
    .o_valid(o_valid), .o_ready(o_ready), .o_re(o_re), .o_im(o_im),
    .o_tag(o_tag), .o_ovf(o_ovf)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi,
                       input logic [7:0] tag);
    a_re    = ar;
    a_im    = ai;
    b_re    = br;
    b_im    = bi;
    i_tag   = tag;
    i_valid = 1'b1;
  endtask

  // Presents the driven sample for one edge, then counts edges until o_valid (bounded).
  task automatic send_wait(output int lat);
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  typedef struct packed {
    logic [15:0] ar, ai, br, bi, re, im;
    logic        ovf;
  } vec_t;

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; i_tag = '0;
    repeat (3) tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b exp 0", o_valid); end
    checks++; if (o_re !== 16'h0 || o_im !== 16'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", o_re, o_im); end
    checks++; if (o_tag !== 8'h0 || o_ovf !== 1'b0) begin errors++; $display("FAIL reset_tag_ovf got %h/%b exp 0/0", o_tag, o_ovf); end
    rst = 1'b0;
    tick();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready got %b exp 1", i_ready); end
  endtask

  task automatic test_vectors();
    vec_t v[8];
    int lat;
    v[0] = '{16'h4000, 16'h4000, 16'h4000, 16'hC000, 16'h4000, 16'h0000, 1'b0};
    v[1] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
    v[2] = '{16'h0001, 16'h0000, 16'h4000, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    v[3] = '{16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    v[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 1'b1};
    v[5] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 1'b1};
    v[6] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFE, 16'h0000, 1'b0};
    v[7] = '{16'h0000, 16'h0001, 16'h4000, 16'h0000, 16'h0000, 16'h0001, 1'b0};
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(v[i].ar, v[i].ai, v[i].br, v[i].bi, 8'(8'hA0 + i));
      send_wait(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL vec%0d_latency got %0d exp 3", i, lat); end
      checks++; if (o_re !== v[i].re) begin errors++; $display("FAIL vec%0d_re got %h exp %h", i, o_re, v[i].re); end
      checks++; if (o_im !== v[i].im) begin errors++; $display("FAIL vec%0d_im got %h exp %h", i, o_im, v[i].im); end
      checks++; if (o_ovf !== v[i].ovf) begin errors++; $display("FAIL vec%0d_ovf got %b exp %b", i, o_ovf, v[i].ovf); end
      checks++; if (o_tag !== 8'(8'hA0 + i)) begin errors++; $display("FAIL vec%0d_tag got %h exp %h", i, o_tag, 8'(8'hA0 + i)); end
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_single got o_valid %b exp 0", i, o_valid); end
    end
  endtask

  // Scoreboard: expected {tag, re, im} queued on input transfer, popped on output transfer.
  task automatic test_stream();
    int k = 0;
    int got = 0;
    logic prev_stall = 1'b0;
    logic [W:0] held = '0;
    logic acc_in, acc_out;
    logic [W-1:0] exp_v;
    for (int c = 0; c < 200 && got < 8; c++) begin
      o_ready = !(c >= 6 && c < 10);
      if (k < 8) drive(16'(k << 11), 16'(k << 10), 16'h4000, 16'h0000, 8'(k));
      else i_valid = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({o_tag, o_re, o_im, o_ovf} !== held) begin
          errors++; $display("FAIL stream_hold c=%0d got %h exp %h", c, {o_tag, o_re, o_im, o_ovf}, held);
        end
      end
      if (o_valid && !o_ready) begin
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL stream_i_ready c=%0d got %b exp 0", c, i_ready); end
      end
      prev_stall = o_valid && !o_ready;
      held = {o_tag, o_re, o_im, o_ovf};
      acc_in  = i_valid && i_ready;
      acc_out = o_valid && o_ready;
      if (acc_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra got tag %h exp none", o_tag);
        end else begin
          exp_v = exp_q.pop_front();
          if ({o_tag, o_re, o_im} !== exp_v) begin
            errors++; $display("FAIL stream_data got %h exp %h", {o_tag, o_re, o_im}, exp_v);
          end
        end
        got++;
      end
      if (acc_in) begin
        exp_q.push_back({8'(k), 16'(k << 10), 16'(k << 9)});
        k++;
      end
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    checks++; if (got !== 8 || exp_q.size() != 0) begin errors++; $display("FAIL stream_count got %0d left %0d exp 8 left 0", got, exp_q.size()); end
    got = 0;
    repeat (6) begin tick(); if (o_valid) got++; end
    checks++; if (got !== 0) begin errors++; $display("FAIL stream_dup got %0d extra exp 0", got); end
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    o_ready = 1'b1;
    drive(16'h4000, 16'h4000, 16'h4000, 16'hC000, 8'h55);
    tick();
    drive(16'h8000, 16'h0000, 16'h8000, 16'h0000, 8'h66);
    tick();
    i_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid got %b exp 0", o_valid); end
    checks++; if (o_re !== 16'h0 || o_im !== 16'h0) begin errors++; $display("FAIL rst_flight_data got %h/%h exp 0/0", o_re, o_im); end
    checks++; if (o_tag !== 8'h0 || o_ovf !== 1'b0) begin errors++; $display("FAIL rst_flight_tag got %h/%b exp 0/0", o_tag, o_ovf); end
    rst = 1'b0;
    repeat (6) begin tick(); if (o_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_flight_stale got %0d results exp 0", seen); end
  endtask

`ifdef CMULT_CONJ_EN
  task automatic test_conj();
    int lat;
    o_ready = 1'b1;
    conj_i = 1'b1;
    drive(16'h4000, 16'h4000, 16'h4000, 16'h4000, 8'h01);
    send_wait(lat);
    checks++; if ({o_re, o_im} !== {16'h4000, 16'h0000}) begin errors++; $display("FAIL conj_on got %h/%h exp 4000/0000", o_re, o_im); end
    conj_i = 1'b0;
    drive(16'h4000, 16'h4000, 16'h4000, 16'h4000, 8'h02);
    send_wait(lat);
    checks++; if ({o_re, o_im} !== {16'h0000, 16'h4000}) begin errors++; $display("FAIL conj_off got %h/%h exp 0000/4000", o_re, o_im); end
    conj_i = 1'b1;
    drive(16'h4000, 16'h0000, 16'h0000, 16'h8000, 8'h03);
    send_wait(lat);
    checks++; if ({o_re, o_im, o_ovf} !== {16'h0000, 16'h4000, 1'b0}) begin errors++; $display("FAIL conj_negsat got %h/%h/%b exp 0000/4000/0", o_re, o_im, o_ovf); end
    conj_i = 1'b0;
    tick();
  endtask
`endif

  initial begin
`ifdef CMULT_CONJ_EN
    conj_i = 1'b0;
`endif
    test_reset();
    test_vectors();
    test_stream();
    test_reset_inflight();
`ifdef CMULT_CONJ_EN
    test_conj();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
